// File: rtl/conv_frame_ctrl_pkg.sv
// Shared widths, state encoding and weight types for the 3x3 convolution
// frame controller.
`timescale 1ns/1ps
package conv_frame_ctrl_pkg;

  localparam int NUM_W     = 9;
  localparam int W_WIDTH   = 17;
  localparam int PIX_WIDTH = 16;

  localparam logic [NUM_W-1:0] W_MASK_FULL = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

  typedef logic signed [W_WIDTH-1:0] weight_t;
  typedef logic [PIX_WIDTH-1:0]      pixel_t;

endpackage

// File: rtl/conv_frame_ctrl_if.sv
// Pixel input stream and result output stream of the convolution frame
// controller; the controller sits on the slave side.
`timescale 1ns/1ps
interface conv_frame_ctrl_if;
  import conv_frame_ctrl_pkg::*;

  logic   in_valid;
  pixel_t in_data;
  logic   in_ready;
  logic   out_valid;
  pixel_t out_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/conv_frame_ctrl_valid_delay.sv
// Two-stage shift of the window-qualification flag, lining it up with the
// registered pipeline result.
`timescale 1ns/1ps
module conv_valid_delay (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [1:0] stage;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     stage <= '0;
    else if (clr) stage <= '0;
    else          stage <= {stage[0], din};
  end

  assign dout = stage[1];

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for a 3x3 convolution pipeline: owns the weights, walks the
// raster, and flags which pipeline results belong to full windows.
`timescale 1ns/1ps
module conv_frame_ctrl
  import conv_frame_ctrl_pkg::*;
#(
  parameter int LENGTH = 4,
  parameter int HEIGHT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     w_we,
  input  logic [3:0]               w_addr,
  input  logic [W_WIDTH-1:0]       w_data,
  conv_frame_ctrl_if.slave         px,
  output logic [PIX_WIDTH-1:0]     pipe_x,
  output logic [NUM_W*W_WIDTH-1:0] pipe_w,
  output logic                     pipe_clr,
  input  logic [PIX_WIDTH-1:0]     pipe_y,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     frame_err,
  output logic                     start_err
);

  localparam int CW = $clog2(LENGTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(LENGTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  state_t           state, state_n;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             flush_cnt;
  weight_t          weights [NUM_W];
  logic [NUM_W-1:0] w_mask;
  logic             start_ok, accept, qualify, w_allowed;
  logic             start_err_q, out_v;
  pixel_t           out_data_q;

  assign start_ok  = (state == ST_IDLE) && start && (w_mask == W_MASK_FULL);
  assign accept    = (state == ST_RUN) && px.in_valid;
  assign qualify   = accept && (row >= RW'(2)) && (col >= CW'(2));
  assign w_allowed = w_we && (state != ST_RUN) && (state != ST_FLUSH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  // The pipeline has no enable, so any gap in the stream during RUN aborts.
  always_comb begin
    state_n     = state;
    px.in_ready = 1'b0;
    busy        = 1'b1;
    frame_done  = 1'b0;
    frame_err   = 1'b0;
    pipe_clr    = !rst;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start_ok) state_n = ST_RUN;
      end
      ST_RUN: begin
        px.in_ready = 1'b1;
        if (!px.in_valid)                          state_n = ST_ABORT;
        else if (row == ROW_LAST && col == COL_LAST) state_n = ST_FLUSH;
      end
      ST_FLUSH: begin
        frame_done = flush_cnt;
        if (flush_cnt) state_n = ST_IDLE;
      end
      ST_ABORT: begin
        frame_err = 1'b1;
        pipe_clr  = 1'b1;
        state_n   = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col       <= '0;
      row       <= '0;
      flush_cnt <= 1'b0;
    end else begin
      flush_cnt <= (state == ST_FLUSH) ? ~flush_cnt : 1'b0;
      if (start_ok) begin
        col <= '0;
        row <= '0;
      end else if (accept) begin
        col <= (col == COL_LAST) ? '0 : col + 1'b1;
        if (col == COL_LAST) row <= row + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_W; i++) weights[i] <= '0;
      w_mask <= '0;
    end else begin
      for (int i = 0; i < NUM_W; i++) begin
        if (w_allowed && w_addr == 4'(i)) begin
          weights[i] <= w_data;
          w_mask[i]  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_err_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      start_err_q <= (state == ST_IDLE) && start && (w_mask != W_MASK_FULL);
      out_data_q  <= pipe_y;
    end
  end

  conv_valid_delay u_valid_delay (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == ST_ABORT),
    .din  (qualify),
    .dout (out_v)
  );

  always_comb begin
    pipe_w = '0;
    for (int i = 0; i < NUM_W; i++) pipe_w[i*W_WIDTH +: W_WIDTH] = weights[i];
  end

  assign pipe_x       = accept ? px.in_data : '0;
  assign px.out_valid = out_v;
  assign px.out_data  = out_data_q;
  assign start_err    = start_err_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Randomized self-checking bench for conv_frame_ctrl with a behavioural 3x3
// pipeline model and a raster-level reference of the expected window results.
`timescale 1ns/1ps
module tb_conv_frame_ctrl;
  import conv_frame_ctrl_pkg::*;

  localparam int L    = 4;
  localparam int H    = 4;
  localparam int NPIX = L * H;
  localparam int NOUT = (H - 2) * (L - 2);

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         w_we = 1'b0;
  logic [3:0]   w_addr = '0;
  logic [16:0]  w_data = '0;
  logic [15:0]  pipe_x;
  logic [152:0] pipe_w;
  logic         pipe_clr;
  logic [15:0]  pipe_y = '0;
  logic         busy, frame_done, frame_err, start_err;

  conv_frame_ctrl_if px();

  conv_frame_ctrl #(.LENGTH(L), .HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .w_we       (w_we),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .px         (px),
    .pipe_x     (pipe_x),
    .pipe_w     (pipe_w),
    .pipe_clr   (pipe_clr),
    .pipe_y     (pipe_y),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .start_err  (start_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mon_idx = 0;
  int ov_count = 0;
  int fd_count = 0;
  int fe_count = 0;

  logic signed [16:0] wt  [9];
  logic [15:0]        frm [NPIX];
  logic [15:0]        got [$];

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q [$];

  always @(posedge clk) cyc++;

  // Behavioural convolution pipeline: a stream shift register that shifts
  // every clock, with w8 on the newest sample and w0 on the oldest.
  logic [15:0] hist [$];
  always @(posedge clk) begin
    longint acc;
    int last, idx;
    if (pipe_clr) begin
      hist.delete();
      pipe_y <= '0;
    end else begin
      hist.push_back(pipe_x);
      if (hist.size() > 2*L + 3) void'(hist.pop_front());
      last = hist.size() - 1;
      acc  = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          idx = last - (2 - i)*L - (2 - j);
          if (idx >= 0)
            acc += longint'($signed(pipe_w[(3*i + j)*17 +: 17])) * longint'(hist[idx]);
        end
      pipe_y <= acc[15:0];
    end
  end

  function automatic logic [15:0] ref_out(int r, int c);
    longint acc = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += longint'(wt[3*i + j]) * longint'(frm[(r - 2 + i)*L + (c - 2 + j)]);
    return acc[15:0];
  endfunction

  // Scoreboard: each pixel about to be accepted is placed in the raster; full
  // windows owe a result two edges after their acceptance edge.
  always @(negedge clk) begin
    logic exp_v;
    int r, c;
    while (exp_q.size() != 0 && exp_q[0].due < cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL missed_out got none expected %0h at cycle %0d", exp_q[0].data, exp_q[0].due);
      void'(exp_q.pop_front());
    end
    exp_v = (exp_q.size() != 0) && (exp_q[0].due == cyc);
    if (px.out_valid || exp_v) begin
      checks++;
      if (px.out_valid !== exp_v) begin
        errors++;
        $display("[TB] FAIL out_valid got %b expected %b at cycle %0d", px.out_valid, exp_v, cyc);
      end else if (px.out_data !== exp_q[0].data) begin
        errors++;
        $display("[TB] FAIL out_data got %0h expected %0h at cycle %0d", px.out_data, exp_q[0].data, cyc);
      end
      if (exp_v) void'(exp_q.pop_front());
    end
    if (px.out_valid) begin
      ov_count++;
      got.push_back(px.out_data);
    end
    if (frame_done) fd_count++;
    if (frame_err)  fe_count++;
    if (px.in_valid && px.in_ready) begin
      r = mon_idx / L;
      c = mon_idx % L;
      if (r >= 2 && c >= 2 && r < H) exp_q.push_back('{due: cyc + 2, data: ref_out(r, c)});
      mon_idx++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus_weight(input int a, input logic [16:0] d);
    w_we   = 1'b1;
    w_addr = 4'(a);
    w_data = d;
    step();
    w_we = 1'b0;
    if (a < 9) wt[a] = d;
  endtask

  // Streams n_pix pixels of frm back to back after a start pulse; optionally
  // issues a weight write to address 4 alongside pixel wr_at.
  task automatic applyStimulus_frame(input int n_pix, input int wr_at);
    mon_idx     = 0;
    start       = 1'b1;
    px.in_valid = 1'b1;
    px.in_data  = frm[0];
    step();
    start = 1'b0;
    for (int k = 0; k < n_pix; k++) begin
      px.in_data  = frm[k];
      px.in_valid = 1'b1;
      if (k == wr_at) begin
        w_we   = 1'b1;
        w_addr = 4'd4;
        w_data = ~wt[4];
      end else begin
        w_we = 1'b0;
      end
      step();
    end
    w_we        = 1'b0;
    px.in_valid = 1'b0;
    px.in_data  = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 9; i++) wt[i] = '0;
    rst         = 1'b0;
    start       = 1'b1;
    w_we        = 1'b1;
    w_addr      = 4'd0;
    w_data      = 17'h5;
    px.in_valid = 1'b1;
    px.in_data  = 16'hABCD;
    repeat (2) @(negedge clk);
    checks++;
    if ({px.in_ready, busy, px.out_valid, frame_done, frame_err, start_err, pipe_clr} !== 7'b0000001) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b expected 0000001",
               {px.in_ready, busy, px.out_valid, frame_done, frame_err, start_err, pipe_clr});
    end
    checks++;
    if ({px.out_data, pipe_x} !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data got %0h expected 0", {px.out_data, pipe_x});
    end
    checks++;
    if (pipe_w !== '0) begin
      errors++;
      $display("[TB] FAIL reset_pipe_w got %0h expected 0", pipe_w);
    end
    @(posedge clk);
    #1;
    start       = 1'b0;
    w_we        = 1'b0;
    px.in_valid = 1'b0;
    px.in_data  = '0;
    rst         = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if ({pipe_clr, busy, px.in_ready} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL post_reset got %b expected 000", {pipe_clr, busy, px.in_ready});
    end
    step();
  endtask

  task automatic test_start_err();
    logic [152:0] exp_pw;
    for (int i = 0; i < 8; i++) applyStimulus_weight(i, 17'($urandom));
    for (int i = 9; i < 16; i++) applyStimulus_weight(i, 17'($urandom));
    exp_pw = '0;
    for (int i = 0; i < 9; i++) exp_pw[i*17 +: 17] = wt[i];
    @(negedge clk);
    checks++;
    if (pipe_w !== exp_pw) begin
      errors++;
      $display("[TB] FAIL weight_regs got %0h expected %0h", pipe_w, exp_pw);
    end
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({start_err, px.in_ready, busy} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL start_err_pulse got %b expected 100", {start_err, px.in_ready, busy});
    end
    step();
    @(negedge clk);
    checks++;
    if ({start_err, px.in_ready, busy} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL start_err_end got %b expected 000", {start_err, px.in_ready, busy});
    end
    step();
  endtask

  task automatic test_identity();
    logic [15:0] id_exp [4];
    int ov_before;
    id_exp = '{16'd10, 16'd11, 16'd14, 16'd15};
    for (int i = 0; i < 8; i++) applyStimulus_weight(i, 17'h0);
    applyStimulus_weight(8, 17'h1);
    for (int k = 0; k < NPIX; k++) frm[k] = 16'(k);
    got.delete();
    ov_before = ov_count;
    applyStimulus_frame(NPIX, -1);
    @(negedge clk);
    checks++;
    if ({frame_done, busy} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL id_flush1 got %b expected 01", {frame_done, busy});
    end
    @(negedge clk);
    checks++;
    if ({frame_done, busy} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL id_done got %b expected 11", {frame_done, busy});
    end
    @(negedge clk);
    checks++;
    if ({frame_done, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL id_idle got %b expected 00", {frame_done, busy});
    end
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("[TB] FAIL id_count got %0d expected 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== id_exp[i]) begin
          errors++;
          $display("[TB] FAIL id_seq[%0d] got %0d expected %0d", i, got[i], id_exp[i]);
        end
      end
    end
    checks++;
    if (ov_count - ov_before != NOUT) begin
      errors++;
      $display("[TB] FAIL id_pulses got %0d expected %0d", ov_count - ov_before, NOUT);
    end
    step();
  endtask

  // Frames with random weights/pixels; when reload is 0 only the first frame
  // gets new weights and carries an illegal mid-frame write to address 4.
  task automatic test_frames(input int n_frames, input bit reload);
    int ov_before;
    for (int f = 0; f < n_frames; f++) begin
      if (reload || f == 0)
        for (int i = 0; i < 9; i++) applyStimulus_weight(i, 17'($urandom));
      for (int k = 0; k < NPIX; k++) frm[k] = 16'($urandom);
      ov_before = ov_count;
      applyStimulus_frame(NPIX, (!reload && f == 0) ? 5 : -1);
      @(negedge clk);
      checks++;
      if ({frame_done, busy} !== 2'b01) begin
        errors++;
        $display("[TB] FAIL frame%0d_flush1 got %b expected 01", f, {frame_done, busy});
      end
      @(negedge clk);
      checks++;
      if ({frame_done, busy} !== 2'b11) begin
        errors++;
        $display("[TB] FAIL frame%0d_done got %b expected 11", f, {frame_done, busy});
      end
      @(negedge clk);
      checks++;
      if ({frame_done, busy, px.in_ready} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL frame%0d_idle got %b expected 000", f, {frame_done, busy, px.in_ready});
      end
      checks++;
      if (ov_count - ov_before != NOUT) begin
        errors++;
        $display("[TB] FAIL frame%0d_pulses got %0d expected %0d", f, ov_count - ov_before, NOUT);
      end
      checks++;
      if (pipe_w[84:68] !== wt[4]) begin
        errors++;
        $display("[TB] FAIL frame%0d_w4 got %0h expected %0h", f, pipe_w[84:68], wt[4]);
      end
      step();
    end
  endtask

  task automatic test_abort();
    int ov_before, fe_before;
    for (int k = 0; k < NPIX; k++) frm[k] = 16'($urandom);
    ov_before = ov_count;
    fe_before = fe_count;
    applyStimulus_frame(6, -1);
    @(negedge clk);
    checks++;
    if ({pipe_clr, frame_err, busy, pipe_x} !== {3'b001, 16'h0}) begin
      errors++;
      $display("[TB] FAIL abort_gap got %0h expected %0h", {pipe_clr, frame_err, busy, pipe_x}, {3'b001, 16'h0});
    end
    @(negedge clk);
    checks++;
    if ({pipe_clr, frame_err, busy, px.in_ready} !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL abort_state got %b expected 1110", {pipe_clr, frame_err, busy, px.in_ready});
    end
    @(negedge clk);
    checks++;
    if ({pipe_clr, frame_err, busy} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_idle got %b expected 000", {pipe_clr, frame_err, busy});
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({ov_count - ov_before, fe_count - fe_before} !== {32'd0, 32'd1}) begin
      errors++;
      $display("[TB] FAIL abort_counts got ov=%0d fe=%0d expected ov=0 fe=1", ov_count - ov_before, fe_count - fe_before);
    end
    step();
  endtask

  task automatic test_reset_midframe();
    int fd_before, fe_before;
    for (int k = 0; k < NPIX; k++) frm[k] = 16'($urandom);
    fd_before = fd_count;
    fe_before = fe_count;
    applyStimulus_frame(9, -1);
    px.in_valid = 1'b1;
    px.in_data  = 16'h1234;
    rst = 1'b0;
    #1;
    checks++;
    if ({px.in_ready, busy, px.out_valid, frame_done, frame_err, start_err, pipe_clr} !== 7'b0000001) begin
      errors++;
      $display("[TB] FAIL midreset_flags got %b expected 0000001",
               {px.in_ready, busy, px.out_valid, frame_done, frame_err, start_err, pipe_clr});
    end
    checks++;
    if ({px.out_data, pipe_x} !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_data got %0h expected 0", {px.out_data, pipe_x});
    end
    for (int i = 0; i < 9; i++) wt[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    px.in_valid = 1'b0;
    px.in_data  = '0;
    rst = 1'b1;
    step();
    checks++;
    if (pipe_w !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_weights got %0h expected 0", pipe_w);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({start_err, px.in_ready, busy} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL midreset_mask got %b expected 100", {start_err, px.in_ready, busy});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({fd_count - fd_before, fe_count - fe_before} !== 64'd0) begin
      errors++;
      $display("[TB] FAIL midreset_pulses got fd=%0d fe=%0d expected 0", fd_count - fd_before, fe_count - fe_before);
    end
    step();
  endtask

  initial begin
    px.in_valid = 1'b0;
    px.in_data  = '0;
    test_reset();
    test_start_err();
    test_identity();
    test_frames(3, 1'b1);
    test_frames(2, 1'b0);
    test_abort();
    test_frames(1, 1'b1);
    test_reset_midframe();
    repeat (4) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_outputs got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/conv_frame_ctrl.md
CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

Interface
REQ-001 SHALL have parameter LENGTH, default 4, image row length in pixels (min 4).
REQ-002 SHALL have parameter HEIGHT, default 4, rows per frame (min 3).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle frame start request.
REQ-006 SHALL have ports w_we/w_addr/w_data  input  1/4/17  weight write strobe, index 0-8, signed coefficient.
REQ-007 SHALL have ports in_valid/in_data  input  1/16; in_ready  output  1; pixel input stream.
REQ-008 SHALL have ports pipe_x  output 16, pipe_w  output 153 (w0 at [16:0] ... w8 at [152:136]), pipe_clr  output 1 (active-high), pipe_y  input 16; convolution pipeline drive and result.
REQ-009 SHALL have ports out_valid  output 1, out_data  output 16; valid-window results, no backpressure.
REQ-010 SHALL have ports busy, frame_done, frame_err, start_err  output  1 each.

Function
REQ-011 SHALL hold 9 weight registers plus 9-bit written mask; w_we with w_addr 0-8 outside RUN/FLUSH writes and sets mask bit; w_addr>8 or write during RUN/FLUSH ignored.
REQ-012 SHALL implement states IDLE, RUN, FLUSH, ABORT.
REQ-013 IDLE: start with mask==9'h1FF -> RUN, clear row/col counters; start with incomplete mask -> stay IDLE, start_err pulses 1 cycle.
REQ-014 RUN: in_ready=1; each in_valid&in_ready edge accepts one pixel; col increments, wraps LENGTH-1->0 with row increment.
REQ-015 SHALL drive pipe_x = in_data combinationally while RUN and in_valid, else 16'h0.
REQ-016 Acceptance of pixel row HEIGHT-1, col LENGTH-1 -> FLUSH.
REQ-017 in_valid low during RUN (after first pixel or not) -> ABORT; pipeline has no enable, so stalls are not tolerated.
REQ-018 ABORT lasts 1 cycle: pipe_clr=1, frame_err pulses, valid pipeline cleared, -> IDLE.
REQ-019 FLUSH lasts 2 cycles, then frame_done pulses 1 cycle with -> IDLE.
REQ-020 Pixel (r,c) accepted at edge E is qualified iff r>=2 and c>=2; out_valid=1 and out_data=registered pipe_y in the cycle after edge E+1 (2-edge latency).
REQ-021 Exactly (HEIGHT-2)*(LENGTH-2) out_valid pulses per completed frame; none for border pixels.
REQ-022 busy=1 in RUN, FLUSH, ABORT; in_ready=0 outside RUN.
REQ-023 start during busy SHALL be ignored without start_err.
REQ-024 Weight mask persists across frames; weights need not be reloaded.

Reset
REQ-025 rst low SHALL immediately force IDLE, counters 0, weights 0, mask 0, valid pipeline 0.
REQ-026 During reset: in_ready, busy, out_valid, frame_done, frame_err, start_err = 0; out_data=0; pipe_clr=1; pipe_x=0.
REQ-027 Reset mid-frame SHALL discard frame with no frame_done or frame_err.

Structure
REQ-028 Shared package SHALL hold state encoding, weight count (9), weight width (17), pixel width (16).
REQ-029 Counter widths SHALL be $clog2(LENGTH) and $clog2(HEIGHT).
REQ-030 One sub-module natural: conv_valid_delay, 2-stage valid shift register aligning qualification with pipe_y.

Verification
REQ-031 Write 9 weights, start, stream 16 pixels LENGTH=HEIGHT=4 continuously -> 4 out_valid pulses, frame_done 2 cycles after last accept.
REQ-032 Write weights 0-7 only, start -> start_err 1 cycle, in_ready stays 0.
REQ-033 Drop in_valid after 6th pixel -> pipe_clr and frame_err 1 cycle, IDLE, no further out_valid.
REQ-034 Assert rst low after 9th pixel -> all outputs 0 immediately, no frame_done; mask cleared.
REQ-035 Weight write to addr 4 during RUN -> pipe_w[84:68] unchanged; second frame without reload succeeds.
REQ-036 Identity kernel (w8=1 others 0) with pixel value = index -> out_data sequence 10,11,14,15.
